timer_irq_master: RTL and testbench

- Avalon-MM initiator that drives the interval timer's s1 slave port (3-bit address, 16-bit data, no waitrequest, registered readdata) and services its irq line.
- Starts the timer, waits for irq, reads and checks status, clears the timeout, and emits a one-cycle tick.
- Restarts the timer if it is found stopped; stops it when disabled.
- Sits between the timer instance and fabric logic that needs a periodic tick without Nios involvement.

---
 rtl/timer_irq_pkg.sv | 40 ++++
 rtl/timer_irq_master.sv | 185 ++++++++++++++++++
 tb/tb_timer_irq_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: shared constants and types for the interval-timer servicing master.
//   - Register addresses of the timer s1 slave port.
//   - Control and status bit indices.
//   - Control words written by the master.
//   - FSM state encoding.
package timer_irq_pkg;

  // Timer s1 register map (16-bit registers)
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  // Control register bit indices
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Status register bit indices
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Control words
  localparam logic [15:0] CTRL_WORD_START_CONT    = 16'h0007;  // ITO|CONT|START
  localparam logic [15:0] CTRL_WORD_START_ONESHOT = 16'h0005;  // ITO|START
  localparam logic [15:0] CTRL_WORD_STOP          = 16'h0008;  // STOP
  localparam logic [15:0] STATUS_WORD_CLEAR       = 16'h0000;  // clears TO

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_START = 3'd1,
    ST_WAIT_IRQ = 3'd2,
    ST_RD_ADDR  = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_WR_CLR   = 3'd5,
    ST_WR_STOP  = 3'd6
  } state_e;

endpackage

// File: rtl/timer_irq_master.sv
// timer_irq_master: Avalon-MM initiator that runs an interval timer and services
// its interrupt, turning each serviced timeout into a one-cycle tick.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              level; high keeps the timer running and serviced
//   m_address/m_chipselect/m_write_n/m_writedata   bus request to timer s1
//   m_readdata          timer readdata, valid the cycle after the address
//   irq                 timer interrupt
//   tick                one-cycle pulse per serviced timeout
//   tick_count          serviced timeouts (wraps)
//   spurious_count      irq seen with TO=0 (saturates)
//   restart_count       timer found stopped in continuous mode (saturates)
//   busy                FSM not idle
module timer_irq_master
  import timer_irq_pkg::*;
#(
  parameter int TICK_W     = 16,
  parameter int ERR_W      = 8,
  parameter int CONTINUOUS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [ERR_W-1:0]  spurious_count,
  output logic [ERR_W-1:0]  restart_count,
  output logic              busy
);

  localparam logic [15:0] START_WORD = (CONTINUOUS != 0) ? CTRL_WORD_START_CONT
                                                         : CTRL_WORD_START_ONESHOT;

  state_e              state_q, state_d;
  logic                run_bit_q, run_bit_d;
  logic                tick_q, tick_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [ERR_W-1:0]    spurious_count_q, spurious_count_d;
  logic [ERR_W-1:0]    restart_count_q, restart_count_d;
  logic                busy_q, busy_d;
  logic [2:0]          m_address_q, m_address_d;
  logic                m_chipselect_q, m_chipselect_d;
  logic                m_write_n_q, m_write_n_d;
  logic [15:0]         m_writedata_q, m_writedata_d;

  // Only TO and RUN are meaningful in the status word.
  logic unused_readdata;
  assign unused_readdata = ^m_readdata[15:2];

  always_comb begin
    state_d          = state_q;
    run_bit_d        = run_bit_q;
    tick_d           = 1'b0;
    tick_count_d     = tick_count_q;
    spurious_count_d = spurious_count_q;
    restart_count_d  = restart_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WR_START;
      end
      ST_WR_START: begin
        state_d = ST_WAIT_IRQ;
      end
      ST_WAIT_IRQ: begin
        if (!enable)  state_d = ST_WR_STOP;
        else if (irq) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        state_d   = ST_WR_CLR;
        run_bit_d = m_readdata[STAT_RUN];
        // The TO outcome is acted on at this edge so that tick and the
        // updated counter are both visible during the WR_CLR cycle.
        if (m_readdata[STAT_TO]) begin
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + TICK_W'(1);
        end else if (spurious_count_q != '1) begin
          spurious_count_d = spurious_count_q + ERR_W'(1);
        end
      end
      ST_WR_CLR: begin
        if (!enable) begin
          state_d = ST_WR_STOP;
        end else if (CONTINUOUS == 0) begin
          state_d = ST_WR_START;
        end else if (!run_bit_q) begin
          state_d = ST_WR_START;
          if (restart_count_q != '1) restart_count_d = restart_count_q + ERR_W'(1);
        end else begin
          state_d = ST_WAIT_IRQ;
        end
      end
      ST_WR_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus request decoded from the next state so each access is presented
    // in exactly the cycle its state is occupied.
    m_chipselect_d = 1'b0;
    m_write_n_d    = 1'b1;
    m_address_d    = 3'd0;
    m_writedata_d  = 16'h0000;
    unique case (state_d)
      ST_WR_START: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CONTROL;
        m_writedata_d  = START_WORD;
      end
      ST_RD_ADDR, ST_RD_DATA: begin
        m_chipselect_d = 1'b1;
        m_address_d    = ADDR_STATUS;
      end
      ST_WR_CLR: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_STATUS;
        m_writedata_d  = STATUS_WORD_CLEAR;
      end
      ST_WR_STOP: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CONTROL;
        m_writedata_d  = CTRL_WORD_STOP;
      end
      default: begin
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      run_bit_q        <= 1'b0;
      tick_q           <= 1'b0;
      tick_count_q     <= '0;
      spurious_count_q <= '0;
      restart_count_q  <= '0;
      busy_q           <= 1'b0;
      m_address_q      <= 3'd0;
      m_chipselect_q   <= 1'b0;
      m_write_n_q      <= 1'b1;
      m_writedata_q    <= 16'h0000;
    end else begin
      state_q          <= state_d;
      run_bit_q        <= run_bit_d;
      tick_q           <= tick_d;
      tick_count_q     <= tick_count_d;
      spurious_count_q <= spurious_count_d;
      restart_count_q  <= restart_count_d;
      busy_q           <= busy_d;
      m_address_q      <= m_address_d;
      m_chipselect_q   <= m_chipselect_d;
      m_write_n_q      <= m_write_n_d;
      m_writedata_q    <= m_writedata_d;
    end
  end

  assign m_address      = m_address_q;
  assign m_chipselect   = m_chipselect_q;
  assign m_write_n      = m_write_n_q;
  assign m_writedata    = m_writedata_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign spurious_count = spurious_count_q;
  assign restart_count  = restart_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_timer_irq_master.sv
// tb_timer_irq_master: drives timer_irq_master against a behavioural interval
// timer (20-cycle period, registered readdata) and checks bus transactions,
// ticks and counters against a transaction-level reference model.
module tb_timer_irq_master;

  localparam int TICK_W  = 16;
  localparam int ERR_W   = 8;
  localparam int PERIOD  = 20;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [2:0]        m_address;
  logic              m_chipselect;
  logic              m_write_n;
  logic [15:0]       m_writedata;
  logic [15:0]       m_readdata;
  logic              irq;
  logic              tick;
  logic [TICK_W-1:0] tick_count;
  logic [ERR_W-1:0]  spurious_count;
  logic [ERR_W-1:0]  restart_count;
  logic              busy;

  always #5 clk = ~clk;

  timer_irq_master #(.TICK_W(TICK_W), .ERR_W(ERR_W), .CONTINUOUS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq(irq),
    .tick(tick), .tick_count(tick_count), .spurious_count(spurious_count),
    .restart_count(restart_count), .busy(busy)
  );

  // ---------------- behavioural interval timer ----------------
  logic        t_ito, t_cont, t_run, t_to;
  int          t_cnt;
  logic [15:0] t_rdata;
  logic        real_irq_en, force_irq, st_ovr_en;
  logic [1:0]  st_ovr;

  assign m_readdata = t_rdata;
  assign irq = force_irq | (real_irq_en & t_to & t_ito);

  always @(posedge clk) begin
    if (reset) begin
      t_ito <= 1'b0; t_cont <= 1'b0; t_run <= 1'b0; t_to <= 1'b0;
      t_cnt <= 0; t_rdata <= 16'h0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= PERIOD - 1;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (m_chipselect && !m_write_n) begin
        if (m_address == 3'd0) begin
          t_to <= 1'b0;
        end else if (m_address == 3'd1) begin
          t_ito  <= m_writedata[0];
          t_cont <= m_writedata[1];
          if (m_writedata[2]) begin t_run <= 1'b1; t_cnt <= PERIOD - 1; end
          if (m_writedata[3]) t_run <= 1'b0;
        end
      end
      t_rdata <= 16'h0;
      if (m_chipselect && m_write_n && m_address == 3'd0)
        t_rdata <= st_ovr_en ? {14'h0, st_ovr} : {14'h0, t_run, t_to};
    end
  end

  // ---------------- bus / tick monitor ----------------
  typedef struct packed {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
    logic        tk;
  } tx_t;

  tx_t txq[$];
  int  tick_seen;

  always @(negedge clk) begin
    if (reset) begin
      txq.delete();
      tick_seen <= 0;
    end else begin
      if (m_chipselect)
        txq.push_back('{wr: !m_write_n, a: m_address, d: m_writedata, tk: tick});
      if (tick) tick_seen <= tick_seen + 1;
    end
  end

  // ---------------- reference model state ----------------
  int checks = 0;
  int errors = 0;
  int exp_ticks = 0;
  int exp_spur = 0;
  int exp_restart = 0;

  function automatic int sat_inc(input int x);
    return (x >= ERR_MAX) ? ERR_MAX : x + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next bus transaction and compare it. Write data is
  // only compared for writes.
  task automatic expect_tx(input string tag, input logic wr, input logic [2:0] a,
                           input logic [15:0] d, input logic tk);
    int  n;
    tx_t t;
    logic [20:0] obs_v, exp_v;
    n = 0;
    while (txq.size() == 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (txq.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed no bus transaction expected wr=%0d addr=%0d", tag, wr, a);
    end
    if (txq.size() > 0) begin
      t = txq.pop_front();
      obs_v = {t.wr, t.a, (t.wr ? t.d : 16'h0), t.tk};
      exp_v = {wr, a, (wr ? d : 16'h0), tk};
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s: observed wr=%0d addr=%0d data=%04h tick=%0d expected wr=%0d addr=%0d data=%04h tick=%0d",
               tag, t.wr, t.a, t.d, t.tk, wr, a, d, tk);
      end
    end
  endtask

  // One forced interrupt whose status readback is v; enable stays high.
  task automatic service(input logic [1:0] v, input string tag);
    st_ovr    = v;
    force_irq = 1'b1;
    expect_tx({tag, " rd_addr"}, 1'b0, 3'd0, 16'h0, 1'b0);
    force_irq = 1'b0;
    expect_tx({tag, " rd_data"}, 1'b0, 3'd0, 16'h0, 1'b0);
    expect_tx({tag, " clear"}, 1'b1, 3'd0, 16'h0000, v[0]);
    if (v[0]) exp_ticks++;
    else      exp_spur = sat_inc(exp_spur);
    if (!v[1]) begin
      expect_tx({tag, " restart"}, 1'b1, 3'd1, 16'h0007, 1'b0);
      exp_restart = sat_inc(exp_restart);
    end
  endtask

  task automatic check_counters(input string tag);
    step();
    check({tag, " tick_count"}, 32'(tick_count), 32'(exp_ticks % (1 << TICK_W)));
    check({tag, " tick_pulses"}, 32'(tick_seen), 32'(exp_ticks));
    check({tag, " spurious_count"}, 32'(spurious_count), 32'(exp_spur));
    check({tag, " restart_count"}, 32'(restart_count), 32'(exp_restart));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    real_irq_en = 1'b1; force_irq = 1'b0; st_ovr_en = 1'b0; st_ovr = 2'b00;

    // Power-up reset
    repeat (3) step();
    check("reset chipselect", 32'(m_chipselect), 32'd0);
    check("reset write_n", 32'(m_write_n), 32'd1);
    check("reset address", 32'(m_address), 32'd0);
    check("reset writedata", 32'(m_writedata), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset tick_count", 32'(tick_count), 32'd0);
    check("reset spurious", 32'(spurious_count), 32'd0);
    check("reset restart", 32'(restart_count), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // Start write lands in the cycle after enable is sampled
    reset = 1'b0; enable = 1'b1;
    step();
    check("start latency", 32'(txq.size()), 32'd1);
    expect_tx("power-up start", 1'b1, 3'd1, 16'h0007, 1'b0);
    repeat (5) step();
    check("idle before irq", 32'(txq.size()), 32'd0);
    check("busy waiting", 32'(busy), 32'd1);

    // Steady run on the real timer
    for (int i = 0; i < 5; i++) begin
      expect_tx($sformatf("steady%0d rd_addr", i), 1'b0, 3'd0, 16'h0, 1'b0);
      expect_tx($sformatf("steady%0d rd_data", i), 1'b0, 3'd0, 16'h0, 1'b0);
      expect_tx($sformatf("steady%0d clear", i), 1'b1, 3'd0, 16'h0000, 1'b1);
      exp_ticks++;
    end
    check_counters("steady");

    // From here the status readback and irq are forced by the bench
    real_irq_en = 1'b0;
    st_ovr_en   = 1'b1;

    service(2'b10, "spurious");
    check_counters("spurious");
    check("spurious busy", 32'(busy), 32'd1);

    service(2'b01, "stopped");
    check_counters("stopped");

    for (int i = 0; i < 40; i++)
      service(2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    check_counters("random");

    for (int i = 0; i < 260; i++)
      service(2'b00, "saturate");
    check_counters("saturate");

    // Disable during RD_ADDR: sequence completes, then stop
    st_ovr    = 2'b11;
    force_irq = 1'b1;
    expect_tx("disable rd_addr", 1'b0, 3'd0, 16'h0, 1'b0);
    enable    = 1'b0;
    force_irq = 1'b0;
    expect_tx("disable rd_data", 1'b0, 3'd0, 16'h0, 1'b0);
    expect_tx("disable clear", 1'b1, 3'd0, 16'h0000, 1'b1);
    exp_ticks++;
    expect_tx("disable stop", 1'b1, 3'd1, 16'h0008, 1'b0);
    step();
    check("disable busy", 32'(busy), 32'd0);
    check("disable bus idle", 32'(txq.size()), 32'd0);

    // Re-enable
    enable = 1'b1;
    step();
    check("reenable latency", 32'(txq.size()), 32'd1);
    expect_tx("reenable start", 1'b1, 3'd1, 16'h0007, 1'b0);

    // Reset during WR_CLR
    st_ovr    = 2'b11;
    force_irq = 1'b1;
    expect_tx("rstclr rd_addr", 1'b0, 3'd0, 16'h0, 1'b0);
    force_irq = 1'b0;
    expect_tx("rstclr rd_data", 1'b0, 3'd0, 16'h0, 1'b0);
    expect_tx("rstclr clear", 1'b1, 3'd0, 16'h0000, 1'b1);
    reset = 1'b1;
    step();
    check("rstclr chipselect", 32'(m_chipselect), 32'd0);
    check("rstclr write_n", 32'(m_write_n), 32'd1);
    check("rstclr tick", 32'(tick), 32'd0);
    check("rstclr tick_count", 32'(tick_count), 32'd0);
    check("rstclr spurious", 32'(spurious_count), 32'd0);
    check("rstclr restart", 32'(restart_count), 32'd0);
    check("rstclr busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_ticks = 0; exp_spur = 0; exp_restart = 0;
    step();
    check("post-reset latency", 32'(txq.size()), 32'd1);
    expect_tx("post-reset start", 1'b1, 3'd1, 16'h0007, 1'b0);
    service(2'b11, "post-reset");
    check_counters("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
